// File: rtl/ms_deco_if.sv
// Microword in, registered datapath controls out.
// The microsequencer drives ms_m; the decoder drives the rest.
`timescale 1ns/1ps
interface ms_deco_if;
  logic [8:0] ms_m;
  logic [2:0] fun;
  logic [5:0] b_sel;
  logic [3:0] cond;
  logic       LE_sel;
  logic [1:0] outbus;
  logic [2:0] c_sel;

  modport master (
    output ms_m,
    input  fun,
    input  b_sel,
    input  cond,
    input  LE_sel,
    input  outbus,
    input  c_sel
  );

  modport slave (
    input  ms_m,
    output fun,
    output b_sel,
    output cond,
    output LE_sel,
    output outbus,
    output c_sel
  );
endinterface

// File: rtl/ms_deco.sv
// Microinstruction field decoder: splits the 9-bit word into A/B/C
// and registers ALU, bus, latch and branch controls (1-cycle latency).
`timescale 1ns/1ps
module ms_deco (
  input  logic     clk,
  input  logic     rst,
  ms_deco_if.slave m
);

  localparam logic [2:0] A_BRANCH = 3'b111;
  localparam logic [2:0] C_NONE   = 3'b000;
  localparam logic [2:0] C_ALUOUT = 3'b110;
  localparam logic [2:0] C_BOUT   = 3'b111;

  localparam logic [1:0] OB_NONE  = 2'b00;
  localparam logic [1:0] OB_ALU   = 2'b01;
  localparam logic [1:0] OB_BBUS  = 2'b10;

  logic [2:0] fld_a;
  logic [2:0] fld_b;
  logic [2:0] fld_c;
  logic       is_br;

  logic [2:0] fun_d,    fun_q;
  logic [5:0] b_sel_d,  b_sel_q;
  logic [3:0] cond_d,   cond_q;
  logic       le_d,     le_q;
  logic [1:0] outbus_d, outbus_q;
  logic [2:0] c_sel_d,  c_sel_q;

  assign fld_a = m.ms_m[8:6];
  assign fld_b = m.ms_m[5:3];
  assign fld_c = m.ms_m[2:0];
  assign is_br = (fld_a == A_BRANCH);

  // B codes 6 and 7 leave the B bus undriven in both modes
  always_comb begin
    b_sel_d = '0;
    unique case (fld_b)
      3'd0:    b_sel_d = 6'b000001;
      3'd1:    b_sel_d = 6'b000010;
      3'd2:    b_sel_d = 6'b000100;
      3'd3:    b_sel_d = 6'b001000;
      3'd4:    b_sel_d = 6'b010000;
      3'd5:    b_sel_d = 6'b100000;
      default: b_sel_d = 6'b000000;
    endcase
  end

  always_comb begin
    fun_d    = '0;
    cond_d   = '0;
    le_d     = 1'b0;
    outbus_d = OB_NONE;
    c_sel_d  = '0;
    unique case (1'b1)
      is_br: begin
        if (fld_c[2])
          cond_d = 4'b0001 << fld_c[1:0];
      end
      !is_br: begin
        fun_d = fld_a;
        unique case (fld_c)
          C_NONE:   ;
          C_ALUOUT: outbus_d = OB_ALU;
          C_BOUT:   outbus_d = OB_BBUS;
          default: begin
            le_d    = 1'b1;
            c_sel_d = fld_c;
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fun_q    <= '0;
      b_sel_q  <= '0;
      cond_q   <= '0;
      le_q     <= 1'b0;
      outbus_q <= '0;
      c_sel_q  <= '0;
    end else begin
      fun_q    <= fun_d;
      b_sel_q  <= b_sel_d;
      cond_q   <= cond_d;
      le_q     <= le_d;
      outbus_q <= outbus_d;
      c_sel_q  <= c_sel_d;
    end
  end

  assign m.fun    = fun_q;
  assign m.b_sel  = b_sel_q;
  assign m.cond   = cond_q;
  assign m.LE_sel = le_q;
  assign m.outbus = outbus_q;
  assign m.c_sel  = c_sel_q;

endmodule

// File: tb/tb_ms_deco.sv
// Directed and exhaustive checks for the microword decoder.
// Outputs packed as {fun,b_sel,cond,LE_sel,outbus,c_sel}.
`timescale 1ns/1ps
module tb_ms_deco;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  ms_deco_if bus ();

  ms_deco dut (
    .clk (clk),
    .rst (rst),
    .m   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] pk(input logic [2:0] f,
                                     input logic [5:0] b,
                                     input logic [3:0] cd,
                                     input logic le,
                                     input logic [1:0] ob,
                                     input logic [2:0] cs);
    return {13'd0, f, b, cd, le, ob, cs};
  endfunction

  function automatic logic [31:0] obs_now();
    return pk(bus.fun, bus.b_sel, bus.cond,
              bus.LE_sel, bus.outbus, bus.c_sel);
  endfunction

  function automatic logic [31:0] model(input logic [8:0] w);
    logic [2:0] a, b, c, f, cs;
    logic [5:0] bs;
    logic [3:0] cd;
    logic       le;
    logic [1:0] ob;
    a = w[8:6]; b = w[5:3]; c = w[2:0];
    f = 3'd0; bs = '0; cd = '0;
    le = 1'b0; ob = 2'd0; cs = 3'd0;
    for (int k = 0; k < 6; k++)
      if (int'(b) == k) bs[k] = 1'b1;
    if (a == 3'd7) begin
      for (int k = 0; k < 4; k++)
        if (c[2] && int'(c[1:0]) == k) cd[k] = 1'b1;
    end else begin
      f = a;
      if (c == 3'd6) ob = 2'd1;
      else if (c == 3'd7) ob = 2'd2;
      else if (c != 3'd0) begin
        le = 1'b1;
        cs = c;
      end
    end
    return pk(f, bs, cd, le, ob, cs);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    bus.ms_m = 9'b001_110_001;

    repeat (3) step();
    chk("rst_hold", obs_now(), 32'd0);
    rst = 1'b0;
    step();
    chk("rst_rel", obs_now(),
        pk(3'b001, 6'b000000, 4'b0000, 1'b1, 2'b00, 3'b001));

    bus.ms_m = 9'b000_010_010;
    #2;
    chk("no_early", obs_now(),
        pk(3'b001, 6'b000000, 4'b0000, 1'b1, 2'b00, 3'b001));
    step();
    chk("wr_r2", obs_now(),
        pk(3'b000, 6'b000100, 4'b0000, 1'b1, 2'b00, 3'b010));

    bus.ms_m = 9'b011_010_110;
    step();
    chk("out_alu", obs_now(),
        pk(3'b011, 6'b000100, 4'b0000, 1'b0, 2'b01, 3'b000));

    bus.ms_m = 9'b100_000_111;
    step();
    chk("out_bbus", obs_now(),
        pk(3'b100, 6'b000001, 4'b0000, 1'b0, 2'b10, 3'b000));

    bus.ms_m = 9'b101_010_000;
    step();
    chk("no_write", obs_now(),
        pk(3'b101, 6'b000100, 4'b0000, 1'b0, 2'b00, 3'b000));

    bus.ms_m = 9'b111_100_100;
    step();
    chk("br_c0", obs_now(),
        pk(3'b000, 6'b010000, 4'b0001, 1'b0, 2'b00, 3'b000));

    bus.ms_m = 9'b111_101_111;
    step();
    chk("br_c3", obs_now(),
        pk(3'b000, 6'b100000, 4'b1000, 1'b0, 2'b00, 3'b000));

    bus.ms_m = 9'b111_000_011;
    step();
    chk("br_none", obs_now(),
        pk(3'b000, 6'b000001, 4'b0000, 1'b0, 2'b00, 3'b000));

    bus.ms_m = 9'b110_111_101;
    step();
    chk("b_idle", obs_now(),
        pk(3'b110, 6'b000000, 4'b0000, 1'b1, 2'b00, 3'b101));

    #3;
    rst = 1'b1;
    #1;
    chk("async_rst", obs_now(), 32'd0);
    step();
    chk("rst_edge", obs_now(), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 512; i++) begin
      bus.ms_m = 9'(i);
      step();
      chk($sformatf("sweep_%0d", i), obs_now(), model(9'(i)));
      chk("inv_ob", 32'(bus.outbus != 2'b11), 32'd1);
      chk("inv_le", 32'(!bus.LE_sel ||
          (bus.c_sel != 3'd0 && bus.outbus == 2'b00)), 32'd1);
      chk("inv_b1h", 32'($onehot0(bus.b_sel)), 32'd1);
      chk("inv_c1h", 32'($onehot0(bus.cond)), 32'd1);
      chk("inv_cbr", 32'(bus.cond == 4'd0 ||
          i[8:6] == 3'b111), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ms_deco.md
Name: ms_deco

Overview:
Microinstruction field decoder for the microprocessor control path. It takes the 9-bit microstore word `ms_m` and splits it into three 3-bit fields:
- A = `ms_m[8:6]`
- B = `ms_m[5:3]`
- C = `ms_m[2:0]`

It then registers the decoded datapath controls: ALU function, B-bus source one-hot, C-bus destination, latch enable, output-bus select and branch condition one-hot. It sits between the microsequencer/microstore and the register file/ALU.

Parameters:
None. All field widths are fixed by the 9-bit microword format.

Ports:
- clk  input  1  system clock; all outputs update on the rising edge
- rst  input  1  asynchronous, active-high reset
- ms_m  input  9  current microinstruction word
- fun  output  3  ALU function code
- b_sel  output  6  one-hot B-bus source select
- cond  output  4  one-hot branch condition select
- LE_sel  output  1  register latch enable, i.e. a C-bus write occurs
- outbus  output  2  output-port source select
- c_sel  output  3  C-bus destination register code

Behaviour:
- **Clocking and reset**
  - One clock; reset is asynchronous and active-high.
  - All outputs are registered. They update on the rising edge of `clk` from the `ms_m` value present before that edge, giving a latency of 1 cycle.
  - While `rst` = 1, every output is 0: `fun` = 000, `b_sel` = 000000, `cond` = 0000, `LE_sel` = 0, `outbus` = 00, `c_sel` = 000. Reset takes effect immediately, not on the next edge.
  - After `rst` deasserts, the first rising edge loads the decode of the current `ms_m`.
  - Reset asserted mid-stream discards the pending decode. Outputs stay 0 until the first edge after deassertion.
- **Mode select on field A**
  - A ≠ 111 is an operate microinstruction.
  - A = 111 is a branch microinstruction.
- **Operate (A ≠ 111)**
  - `fun` = A.
  - `b_sel`: B = 0..5 sets only bit B; B = 6 or 7 gives 000000 (no source, bus idle).
  - C = 000: no write. `LE_sel` = 0, `c_sel` = 000, `outbus` = 00.
  - C = 001..101: register write. `LE_sel` = 1, `c_sel` = C, `outbus` = 00.
  - C = 110: ALU result to output port. `LE_sel` = 0, `c_sel` = 000, `outbus` = 01.
  - C = 111: B bus to output port. `LE_sel` = 0, `c_sel` = 000, `outbus` = 10.
  - `cond` = 0000.
- **Branch (A = 111)**
  - `fun` = 000.
  - `b_sel` = one-hot of B, same rule as operate; this selects the tested operand.
  - `LE_sel` = 0, `c_sel` = 000, `outbus` = 00.
  - C[2] = 0: `cond` = 0000 (no branch).
  - C[2] = 1: `cond` = one-hot with bit C[1:0] set.
- **Output invariants**
  - `outbus` = 11 is never produced.
  - `LE_sel` = 1 implies `c_sel` ≠ 0 and `outbus` = 00.
  - At most one bit of `b_sel` is set; at most one bit of `cond` is set.
  - `cond` is nonzero only when A = 111.
- **Combinational behaviour**
  - Pure function of the registered `ms_m` sample: no other state, no handshake.
  - An X/undefined `ms_m` need not be handled.

Test Plan:
1. Hold `rst` = 1 with `ms_m` = 9'b001_110_001 and toggle `clk` → all outputs stay 0. Release `rst` → after 1 edge: `fun` = 001, `b_sel` = 000000, `c_sel` = 001, `LE_sel` = 1, `outbus` = 00, `cond` = 0000.
2. `ms_m` = 9'b000_010_010 → next edge: `fun` = 000, `b_sel` = 000100, `c_sel` = 010, `LE_sel` = 1, `outbus` = 00, `cond` = 0000. Also check outputs do not change before that edge.
3. `ms_m` = 9'b011_010_110 → `fun` = 011, `b_sel` = 000100, `LE_sel` = 0, `c_sel` = 000, `outbus` = 01. Then `ms_m` = 9'b100_000_111 → `fun` = 100, `b_sel` = 000001, `outbus` = 10.
4. `ms_m` = 9'b101_010_000 → `fun` = 101, `b_sel` = 000100, `LE_sel` = 0, `c_sel` = 000, `outbus` = 00 (no-write case).
5. Branch words:
   - 9'b111_100_100 → `fun` = 000, `b_sel` = 010000, `cond` = 0001, `LE_sel` = 0, `c_sel` = 000.
   - 9'b111_101_111 → `b_sel` = 100000, `cond` = 1000.
   - 9'b111_000_011 → `cond` = 0000.
6. Assert `rst` asynchronously between clock edges while `LE_sel` = 1 → outputs go to 0 immediately. Then sweep all 512 `ms_m` values against a reference model, checking the invariants each cycle.
